// File: rtl/uart_pkg.sv
// uart_pkg: shared UART baud-generator defaults and the divisor config record
// rev 1.0
`default_nettype none

package uart_pkg;

  localparam int DIV_W_DEF      = 16;
  localparam int FRAC_W_DEF     = 4;
  localparam int OVERSAMPLE_DEF = 16;

  typedef struct packed {
    logic [DIV_W_DEF-1:0]  div_int;
    logic [FRAC_W_DEF-1:0] div_frac;
  } baud_cfg_t;

endpackage

`default_nettype wire

// File: rtl/uart_frac_div.sv
// uart_frac_div: fractional clock divider core producing one os event per interval
// rev 1.0
`default_nettype none

module uart_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clear,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_ev
);

  logic [DIV_W-1:0]  cnt_q;
  logic [FRAC_W-1:0] acc_q;
  logic              carry_q;
  logic [DIV_W-1:0]  limit;

  // A carry out of the fractional accumulator stretches the next interval by one clock.
  assign limit = div_int - DIV_W'(1) + DIV_W'(carry_q);
  assign os_ev = en && !clear && (cnt_q == limit);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
    end else if (en) begin
      if (os_ev) begin
        cnt_q            <= '0;
        {carry_q, acc_q} <= {1'b0, acc_q} + {1'b0, div_frac};
      end else begin
        cnt_q <= cnt_q + DIV_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample/bit/mid-bit tick generator with shadowed divisor reconfiguration
// rev 1.0
`default_nettype none

module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W      = DIV_W_DEF,
  parameter int FRAC_W     = FRAC_W_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic              load,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              os_tick,
  output logic              bit_tick,
  output logic              mid_tick,
  output logic              cfg_pend,
  output logic              cfg_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);

  logic [DIV_W-1:0]  act_int_q, shd_int_q;
  logic [FRAC_W-1:0] act_frac_q, shd_frac_q;
  logic              pend_q;
  logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
  logic              os_tick_q, bit_tick_q, mid_tick_q;
  logic              os_ev, bit_ev, mid_ev, err, commit;

  assign err    = (act_int_q == '0);
  assign bit_ev = os_ev && (os_cnt_q == OS_W'(OVERSAMPLE - 1));
  assign mid_ev = os_ev && (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1));
  // Divisor changes only land on a bit boundary, a resync, or while frozen.
  assign commit = bit_ev || resync || !en;

  uart_frac_div #(
    .DIV_W  (DIV_W),
    .FRAC_W (FRAC_W)
  ) u_frac_div (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clear    (resync || err),
    .div_int  (act_int_q),
    .div_frac (act_frac_q),
    .os_ev    (os_ev)
  );

  always_comb begin
    os_cnt_d = os_cnt_q + OS_W'(1);
    if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) os_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      act_int_q  <= '0;
      act_frac_q <= '0;
      shd_int_q  <= '0;
      shd_frac_q <= '0;
      pend_q     <= 1'b0;
      os_cnt_q   <= '0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      mid_tick_q <= 1'b0;
    end else begin
      os_tick_q  <= os_ev;
      bit_tick_q <= bit_ev;
      mid_tick_q <= mid_ev;

      if (resync || err) begin
        os_cnt_q <= '0;
      end else if (os_ev) begin
        os_cnt_q <= os_cnt_d;
      end

      if (commit) begin
        if (load) begin
          act_int_q  <= div_int;
          act_frac_q <= div_frac;
        end else if (pend_q) begin
          act_int_q  <= shd_int_q;
          act_frac_q <= shd_frac_q;
        end
        pend_q <= 1'b0;
      end else if (load) begin
        shd_int_q  <= div_int;
        shd_frac_q <= div_frac;
        pend_q     <= 1'b1;
      end
    end
  end

  assign os_tick  = os_tick_q;
  assign bit_tick = bit_tick_q;
  assign mid_tick = mid_tick_q;
  assign cfg_pend = pend_q;
  assign cfg_err  = err;

endmodule

`default_nettype wire

// File: tb/tb_uart_baud_gen.sv
// tb_uart_baud_gen: directed self-checking bench for uart_baud_gen
// rev 1.0
`default_nettype none

module tb_uart_baud_gen;

  logic        clk = 1'b0;
  logic        rst, en, resync, load;
  logic [15:0] div_int;
  logic [3:0]  div_frac;
  logic        os_tick, bit_tick, mid_tick, cfg_pend, cfg_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_baud_gen dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .resync   (resync),
    .load     (load),
    .div_int  (div_int),
    .div_frac (div_frac),
    .os_tick  (os_tick),
    .bit_tick (bit_tick),
    .mid_tick (mid_tick),
    .cfg_pend (cfg_pend),
    .cfg_err  (cfg_err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // sel: 0 = os_tick, 1 = bit_tick, 2 = mid_tick; t = -1 when the budget expires
  task automatic wait_tick(input int sel, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if ((sel == 0 && os_tick) || (sel == 1 && bit_tick) || (sel == 2 && mid_tick)) begin
        t = cyc;
        break;
      end
    end
  endtask

  // Freeze, load a divisor and restart the phase so each test starts from a known point.
  task automatic restart(input int d, input int f, output int s);
    en = 1'b0; div_int = 16'(d); div_frac = 4'(f); load = 1'b1; resync = 1'b1;
    tick(1);
    load = 1'b0; resync = 1'b0; en = 1'b1;
    s = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; resync = 1'b0; load = 1'b0; div_int = '0; div_frac = '0;
    tick(3);
    rst = 1'b0;
    tick(1);
    checks++; if (os_tick !== 1'b0) begin failures++; $display("FAIL reset_os got=%b exp=0", os_tick); end
    checks++; if (bit_tick !== 1'b0) begin failures++; $display("FAIL reset_bit got=%b exp=0", bit_tick); end
    checks++; if (mid_tick !== 1'b0) begin failures++; $display("FAIL reset_mid got=%b exp=0", mid_tick); end
    checks++; if (cfg_pend !== 1'b0) begin failures++; $display("FAIL reset_pend got=%b exp=0", cfg_pend); end
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL reset_err got=%b exp=1", cfg_err); end
    div_int = 16'd4; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    checks++; if (cfg_pend !== 1'b0) begin failures++; $display("FAIL cfg_bypass_pend got=%b exp=0", cfg_pend); end
  endtask

  task automatic test_integer();
    int s, t;
    en = 1'b1; s = cyc;
    wait_tick(0, 20, t);
    checks++; if (t !== s + 4) begin failures++; $display("FAIL int_os1 got=%0d exp=%0d", t, s + 4); end
    wait_tick(0, 20, t);
    checks++; if (t !== s + 8) begin failures++; $display("FAIL int_os2 got=%0d exp=%0d", t, s + 8); end
    wait_tick(2, 100, t);
    checks++; if (t !== s + 32) begin failures++; $display("FAIL int_mid1 got=%0d exp=%0d", t, s + 32); end
    wait_tick(1, 100, t);
    checks++; if (t !== s + 64) begin failures++; $display("FAIL int_bit1 got=%0d exp=%0d", t, s + 64); end
    checks++; if (os_tick !== 1'b1) begin failures++; $display("FAIL int_bit_os got=%b exp=1", os_tick); end
    wait_tick(2, 100, t);
    checks++; if (t !== s + 96) begin failures++; $display("FAIL int_mid2 got=%0d exp=%0d", t, s + 96); end
    wait_tick(1, 100, t);
    checks++; if (t !== s + 128) begin failures++; $display("FAIL int_bit2 got=%0d exp=%0d", t, s + 128); end
  endtask

  task automatic test_fractional();
    int s, t1, t2, t3, t4, b;
    restart(4, 8, s);
    wait_tick(0, 20, t1);
    wait_tick(0, 20, t2);
    wait_tick(0, 20, t3);
    wait_tick(0, 20, t4);
    checks++; if (t1 !== s + 4) begin failures++; $display("FAIL frac_os1 got=%0d exp=%0d", t1, s + 4); end
    checks++; if (t2 - t1 !== 4) begin failures++; $display("FAIL frac_gap12 got=%0d exp=4", t2 - t1); end
    checks++; if (t3 - t2 !== 5) begin failures++; $display("FAIL frac_gap23 got=%0d exp=5", t3 - t2); end
    checks++; if (t4 - t2 !== 9) begin failures++; $display("FAIL frac_pair got=%0d exp=9", t4 - t2); end
    wait_tick(1, 200, b);
    checks++; if (b !== s + 71) begin failures++; $display("FAIL frac_bit1 got=%0d exp=%0d", b, s + 71); end
    wait_tick(1, 200, t1);
    checks++; if (t1 - b !== 72) begin failures++; $display("FAIL frac_bit_period got=%0d exp=72", t1 - b); end
  endtask

  task automatic test_resync();
    int s, r, q, t;
    restart(4, 0, s);
    tick(22);
    resync = 1'b1;
    tick(1);
    resync = 1'b0; r = cyc;
    checks++; if (os_tick !== 1'b0) begin failures++; $display("FAIL resync_quiet got=%b exp=0", os_tick); end
    wait_tick(0, 20, t);
    checks++; if (t !== r + 4) begin failures++; $display("FAIL resync_os got=%0d exp=%0d", t, r + 4); end
    wait_tick(1, 100, t);
    checks++; if (t !== r + 64) begin failures++; $display("FAIL resync_bit got=%0d exp=%0d", t, r + 64); end
    tick(3);
    resync = 1'b1;
    tick(1);
    resync = 1'b0; q = cyc;
    checks++; if (os_tick !== 1'b0) begin failures++; $display("FAIL resync_suppress got=%b exp=0", os_tick); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 4) begin failures++; $display("FAIL resync_os2 got=%0d exp=%0d", t, q + 4); end
    test_reconfig(q);
  endtask

  task automatic test_reconfig(input int q);
    int t;
    tick(6);
    div_int = 16'd8; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (cfg_pend !== 1'b1) begin failures++; $display("FAIL recfg_pend got=%b exp=1", cfg_pend); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 12) begin failures++; $display("FAIL recfg_old_period got=%0d exp=%0d", t, q + 12); end
    wait_tick(1, 100, t);
    checks++; if (t !== q + 64) begin failures++; $display("FAIL recfg_bit got=%0d exp=%0d", t, q + 64); end
    checks++; if (cfg_pend !== 1'b0) begin failures++; $display("FAIL recfg_commit got=%b exp=0", cfg_pend); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 72) begin failures++; $display("FAIL recfg_new1 got=%0d exp=%0d", t, q + 72); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 80) begin failures++; $display("FAIL recfg_new2 got=%0d exp=%0d", t, q + 80); end
    tick(111);
    div_int = 16'd4; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (bit_tick !== 1'b1) begin failures++; $display("FAIL recfg_coinc_bit got=%b exp=1", bit_tick); end
    checks++; if (cfg_pend !== 1'b0) begin failures++; $display("FAIL recfg_coinc_pend got=%b exp=0", cfg_pend); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 196) begin failures++; $display("FAIL recfg_coinc_os1 got=%0d exp=%0d", t, q + 196); end
    wait_tick(0, 20, t);
    checks++; if (t !== q + 200) begin failures++; $display("FAIL recfg_coinc_os2 got=%0d exp=%0d", t, q + 200); end
  endtask

  task automatic test_zero_div();
    int s, t, n;
    en = 1'b0; div_int = '0; div_frac = '0; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL zero_err got=%b exp=1", cfg_err); end
    en = 1'b1; n = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (os_tick || bit_tick || mid_tick) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL zero_quiet got=%0d exp=0", n); end
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL zero_err_hold got=%b exp=1", cfg_err); end
    en = 1'b0; div_int = 16'd2; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL zero_recover got=%b exp=0", cfg_err); end
    en = 1'b1; s = cyc;
    wait_tick(0, 20, t);
    checks++; if (t !== s + 2) begin failures++; $display("FAIL zero_os1 got=%0d exp=%0d", t, s + 2); end
    wait_tick(0, 20, t);
    checks++; if (t !== s + 4) begin failures++; $display("FAIL zero_os2 got=%0d exp=%0d", t, s + 4); end
    wait_tick(1, 100, t);
    checks++; if (t !== s + 32) begin failures++; $display("FAIL zero_bit got=%0d exp=%0d", t, s + 32); end
  endtask

  task automatic test_freeze_reset();
    int s, t, n;
    restart(4, 0, s);
    tick(6);
    en = 1'b0; n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (os_tick) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL freeze_quiet got=%0d exp=0", n); end
    en = 1'b1;
    wait_tick(0, 20, t);
    checks++; if (t !== s + 18) begin failures++; $display("FAIL freeze_resume got=%0d exp=%0d", t, s + 18); end
    wait_tick(0, 20, t);
    checks++; if (t !== s + 22) begin failures++; $display("FAIL freeze_period got=%0d exp=%0d", t, s + 22); end
    tick(1);
    div_int = 16'd8; load = 1'b1;
    tick(1);
    load = 1'b0;
    checks++; if (cfg_pend !== 1'b1) begin failures++; $display("FAIL rst_pre_pend got=%b exp=1", cfg_pend); end
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (os_tick !== 1'b0) begin failures++; $display("FAIL rst_mid_os got=%b exp=0", os_tick); end
    checks++; if (cfg_pend !== 1'b0) begin failures++; $display("FAIL rst_mid_pend got=%b exp=0", cfg_pend); end
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL rst_mid_err got=%b exp=1", cfg_err); end
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (os_tick || bit_tick || mid_tick) n++;
    end
    checks++; if (n !== 0) begin failures++; $display("FAIL rst_after_quiet got=%0d exp=0", n); end
  endtask

  task automatic test_div_one();
    int s, n_os, n_bit, n_mid;
    restart(1, 0, s);
    n_os = 0; n_bit = 0; n_mid = 0;
    for (int i = 0; i < 32; i++) begin
      tick(1);
      if (os_tick) n_os++;
      if (bit_tick) n_bit++;
      if (mid_tick) n_mid++;
    end
    checks++; if (n_os !== 32) begin failures++; $display("FAIL div1_os got=%0d exp=32", n_os); end
    checks++; if (n_bit !== 2) begin failures++; $display("FAIL div1_bit got=%0d exp=2", n_bit); end
    checks++; if (n_mid !== 2) begin failures++; $display("FAIL div1_mid got=%0d exp=2", n_mid); end
  endtask

  initial begin
    test_reset();
    test_integer();
    test_fractional();
    test_resync();
    test_zero_div();
    test_freeze_reset();
    test_div_one();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised UART baud-tick generator with a fractional divisor, a programmable oversample rate and run-time divisor reconfiguration. It produces an oversample tick for the RX sampler, plus a per-bit tick and a mid-bit tick for the TX shifter and RX data capture. It replaces the fixed 8-bit integer tick divider.

## Interface
- DIV_W, 16: width of integer divisor (clocks per oversample tick).
- FRAC_W, 4: width of fractional divisor; resolution 1/2^FRAC_W clock.
- OVERSAMPLE, 16: oversample ticks per bit; even, >= 4.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  run enable; low freezes all counters, no ticks.
- resync  in  1  restart bit phase (RX start-bit edge); one-cycle pulse.
- load  in  1  capture div_int/div_frac into shadow registers.
- div_int  in  DIV_W  integer clocks per oversample tick.
- div_frac  in  FRAC_W  fractional part, units of 2^-FRAC_W clock.
- os_tick  out  1  oversample tick, one-cycle pulse.
- bit_tick  out  1  bit boundary, one-cycle pulse, coincident with an os_tick.
- mid_tick  out  1  mid-bit, one-cycle pulse, coincident with an os_tick.
- cfg_pend  out  1  shadow divisor loaded, not yet active.
- cfg_err  out  1  active div_int == 0; generator stalled.

## Operation
- Registers: cnt (DIV_W), acc (FRAC_W), carry (1), os_cnt (clog2(OVERSAMPLE)), active and shadow divisor pairs.
- Interval limit = div_int_active - 1 + carry. When cnt == limit: cnt <= 0, os event fires, {carry, acc} <= acc + div_frac_active. Otherwise cnt <= cnt + 1.
- Mean oversample period = div_int + div_frac/2^FRAC_W clocks. Each interval is div_int or div_int+1 clocks.
- On each os event, os_cnt increments and wraps OVERSAMPLE-1 -> 0.
  - bit_tick fires with the event that wraps os_cnt to 0.
  - mid_tick fires with the event that moves os_cnt from OVERSAMPLE/2-1 to OVERSAMPLE/2.
- All tick outputs are registered, one-cycle pulses.
- Priority, highest first: rst, resync, en=0, normal count.
- resync: cnt, acc, carry, os_cnt <= 0; no tick that cycle; pending shadow committed to active.
- en=0: counters hold, ticks 0; pending shadow committed immediately.
- load: shadow <= inputs; cfg_pend <= 1. Repeated loads before commit: last value wins.
- Commit occurs on the cycle bit_tick fires, on resync, or while en=0. Commit sets cfg_pend <= 0. acc and carry are not cleared by a bit_tick commit.
- load in the same cycle as a commit: inputs bypass the shadow and become active directly; cfg_pend stays 0.
- cfg_err = (div_int_active == 0). While set: cnt, os_cnt held at 0, no ticks. Leaves on commit of a nonzero value.

## Timing
- Reset values: all outputs 0; cnt, acc, carry, os_cnt 0; active and shadow divisors 0. After reset cfg_err = 1 until the first load/commit.
- With en=1, D = div_int, F = 0: first os_tick is high D clocks after the first counting cycle, then every D clocks.
- bit_tick is high every OVERSAMPLE*D clocks, first at OVERSAMPLE*D. mid_tick is offset (OVERSAMPLE/2)*D before each bit_tick.
- After resync, the next os_tick is exactly D (+carry = 0) clocks after the resync cycle.
- D = 1, F = 0: os_tick high every cycle.
- rst mid-interval: everything cleared next cycle, including shadow and cfg_pend.

## Structure
- Package uart_pkg holds default DIV_W, FRAC_W and OVERSAMPLE constants, plus a baud_cfg_t struct {div_int, div_frac} shared with uart_tx/uart_rx config registers.
- Sub-module uart_frac_div: cnt/acc/carry core, en/clear/cfg in, os event out.
- Top-level uart_baud_gen contains os_cnt, tick registers and the shadow/commit logic.

## Test plan
- Integer divide: D = 4, F = 0, OVERSAMPLE = 16, en = 1 -> os_tick every 4 clocks, bit_tick every 64, mid_tick 32 clocks before each bit_tick.
- Fractional divide: D = 4, F = 8 (FRAC_W = 4) -> intervals alternate 4, 5; exactly 9 clocks per 2 os_ticks, 72 clocks per bit_tick.
- Resync: pulse resync mid-interval (cnt = 2, os_cnt = 5) -> no tick that cycle; next os_tick 4 clocks later; bit_tick 64 clocks after resync.
- Reconfig: load D = 8 mid-bit -> cfg_pend = 1, old period kept until bit_tick; then 8-clock period, cfg_pend = 0. load coincident with bit_tick -> new value applies immediately.
- Zero divisor: commit D = 0 -> cfg_err = 1, no ticks for 200 clocks; load D = 2 with en = 0 -> cfg_err = 0, os_tick every 2 clocks after en = 1.
- Freeze/reset: en low 10 clocks mid-interval -> tick phase resumes exactly. rst mid-bit -> all outputs 0 next cycle, cfg_err = 1.
